median_window3x3: RTL and testbench
===================================

MEDIAN_WINDOW3X3 -- requirements
Module: median_window3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, giving active pixels per line (range 3..4096).
REQ-003 SHALL have localparam ADDR_WIDTH = clog2(IMG_WIDTH), used for the column counter and the line-buffer address.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: pix_in  input  DATA_WIDTH  raster-order pixel.
REQ-007 SHALL have port: pix_valid  input  1  pix_in is accepted this cycle; no backpressure.
REQ-008 SHALL have port: sof  input  1  start of frame, qualified by pix_valid; marks pixel (x=0, y=0).
REQ-009 SHALL have ports: a0 b0 c0 a1 b1 c1 a2 b2 c2  output  DATA_WIDTH each  3x3 window.
- Digit = row: 0 is two lines ago, 2 is the current line.
- Letter = column: a is two pixels ago, c is the newest pixel.
REQ-010 SHALL have port: win_valid  output  1  the window outputs hold a complete window this cycle.

Function
REQ-011 SHALL keep a column counter x and a line counter y, and advance them only on cycles with pix_valid=1.
REQ-012 SHALL treat an accepted pixel with sof=1 as (0,0) regardless of counter state; any frame in progress is abandoned.
REQ-013 SHALL wrap x from IMG_WIDTH-1 to 0 and then increment y; y saturates at 2, so "y>=2" stays true for the rest of the frame.
REQ-014 SHALL contain two line buffers of IMG_WIDTH entries each: lb_mid holds the previous line and lb_old holds the line before it.
REQ-015 SHALL, on each accepted pixel, perform a read-before-write at address x:
- read old = lb_old[x] and mid = lb_mid[x];
- write lb_old[x] <= mid and lb_mid[x] <= pix_in.
REQ-016 SHALL, on each accepted pixel, shift each row register left (c->b, b->a) and load the new column: c0=old, c1=mid, c2=pix_in.
REQ-017 SHALL register all window outputs; they update on the clock edge that accepts the pixel, giving latency 1 cycle from pix_valid to win_valid.
REQ-018 SHALL assert win_valid for exactly one cycle per accepted pixel whose pre-increment coordinates satisfy x>=2 and y>=2.
REQ-019 SHALL hold win_valid low in all other cycles, including all pix_valid=0 cycles.
REQ-020 SHALL produce no border windows and no padding; a W x H frame yields exactly (W-2)*(H-2) valid windows.
REQ-021 SHALL hold window outputs unchanged on pix_valid=0 cycles.
REQ-022 SHALL output a window with win_valid=1 whose columns all come from the same line triple; stale columns across a line wrap are masked by the x>=2 rule.
REQ-023 SHALL sustain one pixel per clock indefinitely with pix_valid continuously high.

Reset
REQ-024 SHALL, while rst_n=0, clear x, y, all nine window registers and win_valid to 0, asynchronously.
REQ-025 SHALL not clear line-buffer contents; the y>=2 gating makes stale contents unobservable.
REQ-026 SHALL, after deassertion mid-frame, ignore pixels until the next sof, then behave as after power-up.
- Implementation note: track this with a frame_active flag that is cleared by reset and set by sof.

Structure
REQ-027 SHALL place DATA_WIDTH default, IMG_WIDTH default and a clog2 function in the shared image_processing package.
REQ-028 SHALL instantiate sub-module line_buffer twice (parameters DATA_WIDTH, DEPTH).
- Single-port memory, asynchronous read, synchronous write, no reset.
REQ-029 SHALL connect outputs a0..c2 directly, name for name, to the median network inputs; win_valid is carried alongside by the downstream stage.

Verification
REQ-030 SHALL run the bench with IMG_WIDTH=4, DATA_WIDTH=8 and pixel value 16*y+x.
REQ-031 Scenario: 4x4 frame, continuous pix_valid -> 4 win_valid pulses.
- First pulse is one cycle after pixel (2,2).
- First window: a0..c0=00,01,02; a1..c1=10,11,12; a2..c2=20,21,22.
REQ-032 Scenario: line wrap -> after the pulse for pixel (3,2), pixels (0,3) and (1,3) give no pulse.
- Pixel (2,3) gives a0=10, c0=12, a2=30, c2=32.
REQ-033 Scenario: same frame with pix_valid=0 inserted every other cycle -> identical window sequence; outputs held during gaps.
REQ-034 Scenario: sof asserted at pixel (1,2) of frame 1, then a full frame 2 -> no pulse until frame-2 pixel (2,2), then exactly 4 pulses.
REQ-035 Scenario: rst_n pulsed low mid-line 2 -> outputs and win_valid read 0 immediately.
- Pixels without sof are ignored; the next sof frame yields 4 correct windows.
REQ-036 Scenario: random 8x6 frames with IMG_WIDTH=8 -> every window matches a reference model and the count is 24 per frame.

Source files
------------

// File: rtl/median_window3x3_pkg.sv
// Shared constants and helpers for the 3x3 window front end of the median filter.
package median_window3x3_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefImgWidth  = 640;

    // Constant-evaluable ceil(log2(v)); returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/median_window3x3_if.sv
// Pixel-in / window-out bundle between the raster source and the 3x3 window stage.
interface median_window3x3_if
    import median_window3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
);
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  sof;
    logic [DATA_WIDTH-1:0] a0, b0, c0;
    logic [DATA_WIDTH-1:0] a1, b1, c1;
    logic [DATA_WIDTH-1:0] a2, b2, c2;
    logic                  win_valid;

    modport master (
        output pix_in, pix_valid, sof,
        input  a0, b0, c0, a1, b1, c1, a2, b2, c2, win_valid
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output a0, b0, c0, a1, b1, c1, a2, b2, c2, win_valid
    );
endinterface

// File: rtl/median_window3x3_line_buffer.sv
// One video line of storage: asynchronous read, synchronous write, no reset.
module line_buffer
    import median_window3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefImgWidth,
    localparam int unsigned AddrWidth = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AddrWidth-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/median_window3x3.sv
// Builds a registered 3x3 pixel window from a raster stream using two line buffers;
// win_valid flags windows that lie fully inside the frame.
module median_window3x3
    import median_window3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned IMG_WIDTH  = DefImgWidth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    median_window3x3_if.slave        bus
);
    localparam int unsigned ADDR_WIDTH = clog2(IMG_WIDTH);

    logic [ADDR_WIDTH-1:0] r_x;
    logic [1:0]            r_y;
    logic                  r_active;
    logic [DATA_WIDTH-1:0] r_a0, r_b0, r_c0, r_a1, r_b1, r_c1, r_a2, r_b2, r_c2;
    logic                  r_win_valid;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_x;
    logic [1:0]            w_y;
    logic [DATA_WIDTH-1:0] w_mid;
    logic [DATA_WIDTH-1:0] w_old;

    // Pixels arriving after a reset are dropped until a sof restarts the frame.
    assign w_accept = bus.pix_valid & (bus.sof | r_active);
    assign w_x      = bus.sof ? '0 : r_x;
    assign w_y      = bus.sof ? '0 : r_y;

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb_mid (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_x),
        .i_wdata (bus.pix_in),
        .o_rdata (w_mid)
    );

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb_old (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_x),
        .i_wdata (w_mid),
        .o_rdata (w_old)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_active    <= 1'b0;
            r_a0        <= '0;
            r_b0        <= '0;
            r_c0        <= '0;
            r_a1        <= '0;
            r_b1        <= '0;
            r_c1        <= '0;
            r_a2        <= '0;
            r_b2        <= '0;
            r_c2        <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            if (w_accept) begin
                r_active <= 1'b1;
                if (w_x == ADDR_WIDTH'(IMG_WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= (w_y == 2'd2) ? w_y : w_y + 2'd1;
                end else begin
                    r_x <= w_x + ADDR_WIDTH'(1);
                    r_y <= w_y;
                end
                r_a0        <= r_b0;
                r_b0        <= r_c0;
                r_c0        <= w_old;
                r_a1        <= r_b1;
                r_b1        <= r_c1;
                r_c1        <= w_mid;
                r_a2        <= r_b2;
                r_b2        <= r_c2;
                r_c2        <= bus.pix_in;
                // Columns from the previous line are still in a/b until x reaches 2.
                r_win_valid <= (w_x >= ADDR_WIDTH'(2)) && (w_y == 2'd2);
            end
        end
    end

    assign bus.a0        = r_a0;
    assign bus.b0        = r_b0;
    assign bus.c0        = r_c0;
    assign bus.a1        = r_a1;
    assign bus.b1        = r_b1;
    assign bus.c1        = r_c1;
    assign bus.a2        = r_a2;
    assign bus.b2        = r_b2;
    assign bus.c2        = r_c2;
    assign bus.win_valid = r_win_valid;

endmodule

// File: tb/tb_median_window3x3.sv
// Bench for median_window3x3: directed 4-wide scenarios and random 8x6 frames,
// checked against a frame-array model of the 3x3 window.
module tb_median_window3x3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    median_window3x3_if #(.DATA_WIDTH(8)) bus4 ();
    median_window3x3_if #(.DATA_WIDTH(8)) bus8 ();

    median_window3x3 #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (4)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    median_window3x3 #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (8)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the frame as a 2D array plus raster position per instance.
    int          mx      [2];
    int          my      [2];
    bit          act     [2];
    logic [7:0]  img     [2][64][8];
    logic [71:0] exp_win [2];
    bit          known   [2];
    int          pulses  [2];

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] get_win(input int inst);
        if (inst == 0) begin
            return {bus4.a0, bus4.b0, bus4.c0, bus4.a1, bus4.b1, bus4.c1,
                    bus4.a2, bus4.b2, bus4.c2};
        end
        return {bus8.a0, bus8.b0, bus8.c0, bus8.a1, bus8.b1, bus8.c1,
                bus8.a2, bus8.b2, bus8.c2};
    endfunction

    function automatic logic get_wv(input int inst);
        return (inst == 0) ? bus4.win_valid : bus8.win_valid;
    endfunction

    task automatic drive(input int inst, input logic v, input logic s, input logic [7:0] p);
        if (inst == 0) begin
            bus4.pix_valid = v;
            bus4.sof       = s;
            bus4.pix_in    = p;
        end else begin
            bus8.pix_valid = v;
            bus8.sof       = s;
            bus8.pix_in    = p;
        end
    endtask

    // One clock: present a beat, advance the model, check outputs just after the edge.
    task automatic step(input int inst, input logic v, input logic s, input logic [7:0] p,
                        input string tag);
        logic        ev;
        logic [71:0] w;
        int          width;
        ev    = 1'b0;
        w     = '0;
        width = (inst == 0) ? 4 : 8;
        @(negedge clk);
        drive(inst, v, s, p);
        if (v) begin
            if (s) begin
                mx[inst]  = 0;
                my[inst]  = 0;
                act[inst] = 1'b1;
            end
            if (act[inst]) begin
                img[inst][my[inst]][mx[inst]] = p;
                if (mx[inst] >= 2 && my[inst] >= 2) begin
                    ev = 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            w[71 - 8 * (3 * r + c) -: 8] =
                                img[inst][my[inst] - 2 + r][mx[inst] - 2 + c];
                        end
                    end
                    exp_win[inst] = w;
                end
                known[inst] = ev;
                if (mx[inst] == width - 1) begin
                    mx[inst] = 0;
                    if (my[inst] < 63) my[inst]++;
                end else begin
                    mx[inst]++;
                end
            end
        end
        @(posedge clk);
        #1;
        drive(inst, 1'b0, 1'b0, 8'h00);
        check_eq({tag, "_vld"}, 72'(get_wv(inst)), 72'(ev));
        if (get_wv(inst)) pulses[inst]++;
        if (known[inst]) check_eq({tag, "_win"}, get_win(inst), exp_win[inst]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_win", get_win(i), 72'h0);
            check_eq("rst_vld", 72'(get_wv(i)), 72'h0);
            act[i]     = 1'b0;
            known[i]   = 1'b1;
            exp_win[i] = '0;
            mx[i]      = 0;
            my[i]      = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame4(input bit gaps, input string tag);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                step(0, 1'b1, (x == 0 && y == 0), 8'(16 * y + x), tag);
                if (gaps) step(0, 1'b0, 1'b0, 8'hEE, {tag, "_gap"});
            end
        end
    endtask

    initial begin
        logic [71:0] w;
        int          gap_pick;
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        do_reset();

        // 4x4 frame, continuous, with the first window and the post-wrap window pinned down.
        pulses[0] = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                step(0, 1'b1, (x == 0 && y == 0), 8'(16 * y + x), "cont");
                if (x == 2 && y == 2) begin
                    check_eq("first_win", get_win(0), 72'h000102_101112_202122);
                end
                if (x == 2 && y == 3) begin
                    w = get_win(0);
                    check_eq("wrap_a0", 72'(w[71:64]), 72'h10);
                    check_eq("wrap_c0", 72'(w[55:48]), 72'h12);
                    check_eq("wrap_a2", 72'(w[23:16]), 72'h30);
                    check_eq("wrap_c2", 72'(w[7:0]), 72'h32);
                end
            end
        end
        check_eq("cont_pulses", 72'(pulses[0]), 72'd4);

        // Same frame with idle beats interleaved.
        pulses[0] = 0;
        frame4(1'b1, "gaps");
        check_eq("gaps_pulses", 72'(pulses[0]), 72'd4);

        // sof lands where frame 1 would be at (1,2).
        pulses[0] = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 1'b1, (i == 0), 8'(8'hA0 + 16 * (i / 4) + (i % 4)), "abort1");
        end
        frame4(1'b0, "abort2");
        check_eq("abort_pulses", 72'(pulses[0]), 72'd4);

        // Reset mid-line 2, orphan pixels, then a clean frame.
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, (i == 0), 8'(16 * (i / 4) + (i % 4)), "prerst");
        end
        do_reset();
        pulses[0] = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, 1'b0, 8'(8'h55 + i), "orphan");
        end
        frame4(1'b0, "postrst");
        check_eq("postrst_pulses", 72'(pulses[0]), 72'd4);

        // Random 8x6 frames on the 8-wide instance, with random idle beats.
        for (int f = 0; f < 3; f++) begin
            pulses[1] = 0;
            for (int y = 0; y < 6; y++) begin
                for (int x = 0; x < 8; x++) begin
                    step(1, 1'b1, (x == 0 && y == 0), 8'($urandom_range(0, 255)), "rnd");
                    gap_pick = $urandom_range(0, 3);
                    if (gap_pick == 0) step(1, 1'b0, 1'b0, 8'($urandom), "rnd_gap");
                end
            end
            check_eq("rnd_pulses", 72'(pulses[1]), 72'd24);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
